// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Phase, level, lives and scoring controller for the symbol-counting game.
// Sequences PRELIM -> GAME -> ANSWER -> POST once per level, driven by a 1 Hz
// strobe. It counts the player's up/down presses, judges the answer against
// the symbol generator's count, and decides between next level, retry, WIN
// and LOSE.
//
// Ports:
//   Clk100M     in   system clock
//   reset       in   synchronous, active-high reset
//   tick        in   one-cycle 1 Hz strobe
//   startBtn    in   one-cycle start pulse (honoured in IDLE, WIN, LOSE)
//   userUp      in   one-cycle increment pulse
//   userDown    in   one-cycle decrement pulse
//   magicCount  in   symbol-generator special count, stable from stopGen on
//   phase       out  0 IDLE, 1 PRELIM, 2 GAME, 3 ANSWER, 4 POST, 5 WIN, 6 LOSE
//   secsLeft    out  seconds remaining in a timed phase, 0 otherwise
//   curLevel    out  current level, 0-based
//   livesLeft   out  remaining lives
//   userCount   out  player's running count
//   difference  out  registered |userCount - magicCount|
//   levelPass   out  registered pass verdict, valid in POST
//   startGen    out  one-cycle pulse after entering GAME
//   stopGen     out  one-cycle pulse after leaving GAME
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int NUM_LEVELS  = 8,
  parameter int LVL_W       = 4,
  parameter int CNT_W       = 8,
  parameter int PRELIM_SECS = 3,
  parameter int GAME_SECS   = 20,
  parameter int GAME_DEC    = 2,
  parameter int GAME_MIN    = 5,
  parameter int ANSWER_SECS = 5,
  parameter int POST_SECS   = 3,
  parameter int TOL         = 0,
  parameter int LIVES       = 3
) (
  input  logic             Clk100M,
  input  logic             reset,
  input  logic             tick,
  input  logic             startBtn,
  input  logic             userUp,
  input  logic             userDown,
  input  logic [CNT_W-1:0] magicCount,
  output logic [2:0]       phase,
  output logic [7:0]       secsLeft,
  output logic [LVL_W-1:0] curLevel,
  output logic [3:0]       livesLeft,
  output logic [CNT_W-1:0] userCount,
  output logic [CNT_W-1:0] difference,
  output logic             levelPass,
  output logic             startGen,
  output logic             stopGen
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    GAME   = 3'd2,
    ANSWER = 3'd3,
    POST   = 3'd4,
    WIN    = 3'd5,
    LOSE   = 3'd6
  } phaseT;

  localparam int LVL_SLOTS = 2 ** LVL_W;

  localparam logic [7:0]       PRELIM_DUR = 8'(PRELIM_SECS);
  localparam logic [7:0]       ANSWER_DUR = 8'(ANSWER_SECS);
  localparam logic [7:0]       POST_DUR   = 8'(POST_SECS);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [31:0]      TOL_U      = 32'(TOL);

  // State registers
  phaseT            phaseReg, phaseNext;
  logic [7:0]       secsReg, secsNext;
  logic [LVL_W-1:0] levelReg, levelNext;
  logic [3:0]       livesReg, livesNext;
  logic [CNT_W-1:0] countReg, countNext;
  logic [CNT_W-1:0] diffReg, diffNext;
  logic             passReg, passNext;
  logic             startGenReg, startGenNext;
  logic             stopGenReg, stopGenNext;

  // Combinational helpers
  logic             lastTick;
  logic             enterPrelim;
  logic [CNT_W-1:0] diffCalc;
  logic [31:0]      diffWide;

  // GAME duration per level, resolved at elaboration. The subtraction is only
  // taken when it cannot drop below the floor, so it never underflows. The
  // table covers every encodable level so indexing by levelReg is always legal.
  logic [7:0] gameDurTable [LVL_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < LVL_SLOTS; gi++) begin : gGameDur
      localparam int CUT = gi * GAME_DEC;
      localparam int DUR = (GAME_SECS >= CUT + GAME_MIN) ? (GAME_SECS - CUT) : GAME_MIN;
      assign gameDurTable[gi] = 8'(DUR);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      phaseReg    <= IDLE;
      secsReg     <= 8'd0;
      levelReg    <= '0;
      livesReg    <= LIVES_INIT;
      countReg    <= '0;
      diffReg     <= '0;
      passReg     <= 1'b0;
      startGenReg <= 1'b0;
      stopGenReg  <= 1'b0;
    end else begin
      phaseReg    <= phaseNext;
      secsReg     <= secsNext;
      levelReg    <= levelNext;
      livesReg    <= livesNext;
      countReg    <= countNext;
      diffReg     <= diffNext;
      passReg     <= passNext;
      startGenReg <= startGenNext;
      stopGenReg  <= stopGenNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    phaseNext    = phaseReg;
    secsNext     = secsReg;
    levelNext    = levelReg;
    livesNext    = livesReg;
    countNext    = countReg;
    diffNext     = diffReg;
    passNext     = passReg;
    startGenNext = 1'b0;
    stopGenNext  = 1'b0;
    enterPrelim  = 1'b0;

    // The phase ends on the tick that would take secsLeft from 1 to 0.
    lastTick = tick && (secsReg == 8'd1);

    // The player's count moves only while the game or answer window is open.
    // Opposing presses in the same cycle cancel.
    if ((phaseReg == GAME) || (phaseReg == ANSWER)) begin
      if (userUp && !userDown && (countReg != CNT_MAX)) begin
        countNext = countReg + CNT_ONE;
      end else if (userDown && !userUp && (countReg != '0)) begin
        countNext = countReg - CNT_ONE;
      end
    end

    // Judge against the count as it will be after this edge, so a press that
    // lands on the final ANSWER tick still counts.
    diffCalc = (countNext >= magicCount) ? (countNext - magicCount)
                                         : (magicCount - countNext);
    diffWide = 32'(diffCalc);

    case (phaseReg)
      IDLE: begin
        // A start in the same cycle as a tick begins PRELIM with a full count.
        if (startBtn) begin
          enterPrelim = 1'b1;
        end
      end

      WIN, LOSE: begin
        if (startBtn) begin
          enterPrelim = 1'b1;
          levelNext   = '0;
          livesNext   = LIVES_INIT;
        end
      end

      PRELIM: begin
        if (lastTick) begin
          phaseNext    = GAME;
          secsNext     = gameDurTable[levelReg];
          startGenNext = 1'b1;
        end else if (tick) begin
          secsNext = secsReg - 8'd1;
        end
      end

      GAME: begin
        if (lastTick) begin
          phaseNext   = ANSWER;
          secsNext    = ANSWER_DUR;
          stopGenNext = 1'b1;
        end else if (tick) begin
          secsNext = secsReg - 8'd1;
        end
      end

      ANSWER: begin
        if (lastTick) begin
          phaseNext = POST;
          secsNext  = POST_DUR;
          diffNext  = diffCalc;
          passNext  = (diffWide <= TOL_U);
        end else if (tick) begin
          secsNext = secsReg - 8'd1;
        end
      end

      POST: begin
        if (lastTick) begin
          if (passReg) begin
            if (levelReg == LAST_LEVEL) begin
              phaseNext = WIN;
              secsNext  = 8'd0;
            end else begin
              levelNext   = levelReg + LVL_ONE;
              enterPrelim = 1'b1;
            end
          end else begin
            livesNext = livesReg - 4'd1;
            if (livesReg == 4'd1) begin
              phaseNext = LOSE;
              secsNext  = 8'd0;
            end else begin
              enterPrelim = 1'b1;
            end
          end
        end else if (tick) begin
          secsNext = secsReg - 8'd1;
        end
      end

      default: begin
        // Unused encoding: recover to IDLE.
        phaseNext = IDLE;
        secsNext  = 8'd0;
      end
    endcase

    // Every PRELIM entry starts the level from a clean score.
    if (enterPrelim) begin
      phaseNext = PRELIM;
      secsNext  = PRELIM_DUR;
      countNext = '0;
      diffNext  = '0;
      passNext  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all registered, no decode beyond a direct map.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase      = phaseReg;
    secsLeft   = secsReg;
    curLevel   = levelReg;
    livesLeft  = livesReg;
    userCount  = countReg;
    difference = diffReg;
    levelPass  = passReg;
    startGen   = startGenReg;
    stopGen    = stopGenReg;
  end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Directed bench for game_sequencer using a shortened game:
// NUM_LEVELS=2, PRELIM=2 s, GAME=4 s (3 s at level 1), ANSWER=2 s, POST=1 s,
// TOL=1, LIVES=2, CNT_W=4. Inputs change 1 ns after a rising edge and outputs
// are sampled at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int NUM_LEVELS  = 2;
  localparam int LVL_W       = 4;
  localparam int CNT_W       = 4;
  localparam int PRELIM_SECS = 2;
  localparam int GAME_SECS   = 4;
  localparam int GAME_DEC    = 1;
  localparam int GAME_MIN    = 3;
  localparam int ANSWER_SECS = 2;
  localparam int POST_SECS   = 1;
  localparam int TOL         = 1;
  localparam int LIVES       = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             startBtn = 1'b0;
  logic             userUp = 1'b0;
  logic             userDown = 1'b0;
  logic [CNT_W-1:0] magicCount = '0;
  logic [2:0]       phase;
  logic [7:0]       secsLeft;
  logic [LVL_W-1:0] curLevel;
  logic [3:0]       livesLeft;
  logic [CNT_W-1:0] userCount;
  logic [CNT_W-1:0] difference;
  logic             levelPass;
  logic             startGen;
  logic             stopGen;

  int checks = 0;
  int errors = 0;

  game_sequencer #(
    .NUM_LEVELS (NUM_LEVELS),
    .LVL_W      (LVL_W),
    .CNT_W      (CNT_W),
    .PRELIM_SECS(PRELIM_SECS),
    .GAME_SECS  (GAME_SECS),
    .GAME_DEC   (GAME_DEC),
    .GAME_MIN   (GAME_MIN),
    .ANSWER_SECS(ANSWER_SECS),
    .POST_SECS  (POST_SECS),
    .TOL        (TOL),
    .LIVES      (LIVES)
  ) dut (
    .Clk100M   (clk),
    .reset     (reset),
    .tick      (tick),
    .startBtn  (startBtn),
    .userUp    (userUp),
    .userDown  (userDown),
    .magicCount(magicCount),
    .phase     (phase),
    .secsLeft  (secsLeft),
    .curLevel  (curLevel),
    .livesLeft (livesLeft),
    .userCount (userCount),
    .difference(difference),
    .levelPass (levelPass),
    .startGen  (startGen),
    .stopGen   (stopGen)
  );

  always #5 clk = ~clk;

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doTick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) doTick();
  endtask

  task automatic doStart();
    startBtn = 1'b1; step(); startBtn = 1'b0;
  endtask

  task automatic doUps(input int n);
    for (int i = 0; i < n; i++) begin
      userUp = 1'b1; step(); userUp = 1'b0;
    end
  endtask

  task automatic doDowns(input int n);
    for (int i = 0; i < n; i++) begin
      userDown = 1'b1; step(); userDown = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_phase: got %0d expected 0", phase); end
    checks++; if (secsLeft !== 8'd0) begin errors++; $display("FAIL rst_secs: got %0d expected 0", secsLeft); end
    checks++; if (curLevel !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", curLevel); end
    checks++; if (livesLeft !== 4'd2) begin errors++; $display("FAIL rst_lives: got %0d expected 2", livesLeft); end
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", userCount); end
    checks++; if (difference !== 4'd0) begin errors++; $display("FAIL rst_diff: got %0d expected 0", difference); end
    checks++; if (levelPass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %0d expected 0", levelPass); end
    checks++; if (startGen !== 1'b0) begin errors++; $display("FAIL rst_startGen: got %0d expected 0", startGen); end
    checks++; if (stopGen !== 1'b0) begin errors++; $display("FAIL rst_stopGen: got %0d expected 0", stopGen); end
    doTick();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL idle_tick_phase: got %0d expected 0", phase); end
    checks++; if (secsLeft !== 8'd0) begin errors++; $display("FAIL idle_tick_secs: got %0d expected 0", secsLeft); end
    $display("test_reset done: phase=%0d lives=%0d", phase, livesLeft);
  endtask

  task automatic test_phase_timing();
    magicCount = 4'd5;
    doStart();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL start_phase: got %0d expected 1", phase); end
    checks++; if (secsLeft !== 8'd2) begin errors++; $display("FAIL start_secs: got %0d expected 2", secsLeft); end
    doUps(1);
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL prelim_nocount: got %0d expected 0", userCount); end
    doTick();
    checks++; if (secsLeft !== 8'd1) begin errors++; $display("FAIL prelim_dec: got %0d expected 1", secsLeft); end
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL prelim_hold: got %0d expected 1", phase); end
    doTick();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL game_phase: got %0d expected 2", phase); end
    checks++; if (secsLeft !== 8'd4) begin errors++; $display("FAIL game_secs0: got %0d expected 4", secsLeft); end
    checks++; if (startGen !== 1'b1) begin errors++; $display("FAIL startGen_hi: got %0d expected 1", startGen); end
    step();
    checks++; if (startGen !== 1'b0) begin errors++; $display("FAIL startGen_lo: got %0d expected 0", startGen); end
    doStart();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL start_ignored_phase: got %0d expected 2", phase); end
    checks++; if (secsLeft !== 8'd4) begin errors++; $display("FAIL start_ignored_secs: got %0d expected 4", secsLeft); end
    doTicks(3);
    checks++; if (secsLeft !== 8'd1) begin errors++; $display("FAIL game_dec: got %0d expected 1", secsLeft); end
    checks++; if (stopGen !== 1'b0) begin errors++; $display("FAIL stopGen_early: got %0d expected 0", stopGen); end
    doTick();
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL answer_phase: got %0d expected 3", phase); end
    checks++; if (secsLeft !== 8'd2) begin errors++; $display("FAIL answer_secs: got %0d expected 2", secsLeft); end
    checks++; if (stopGen !== 1'b1) begin errors++; $display("FAIL stopGen_hi: got %0d expected 1", stopGen); end
    step();
    checks++; if (stopGen !== 1'b0) begin errors++; $display("FAIL stopGen_lo: got %0d expected 0", stopGen); end
    $display("test_phase_timing done: phase=%0d secs=%0d", phase, secsLeft);
  endtask

  task automatic test_pass_level0();
    doUps(5);
    checks++; if (userCount !== 4'd5) begin errors++; $display("FAIL answer_count: got %0d expected 5", userCount); end
    doTick();
    // Sixth press lands on the final ANSWER tick and must be judged.
    userUp = 1'b1; tick = 1'b1; step(); userUp = 1'b0; tick = 1'b0;
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL post_phase: got %0d expected 4", phase); end
    checks++; if (secsLeft !== 8'd1) begin errors++; $display("FAIL post_secs: got %0d expected 1", secsLeft); end
    checks++; if (userCount !== 4'd6) begin errors++; $display("FAIL post_count: got %0d expected 6", userCount); end
    checks++; if (difference !== 4'd1) begin errors++; $display("FAIL pass_diff: got %0d expected 1", difference); end
    checks++; if (levelPass !== 1'b1) begin errors++; $display("FAIL pass_verdict: got %0d expected 1", levelPass); end
    doUps(1);
    checks++; if (userCount !== 4'd6) begin errors++; $display("FAIL post_nocount: got %0d expected 6", userCount); end
    doTick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL lvl1_phase: got %0d expected 1", phase); end
    checks++; if (curLevel !== 4'd1) begin errors++; $display("FAIL lvl1_level: got %0d expected 1", curLevel); end
    checks++; if (livesLeft !== 4'd2) begin errors++; $display("FAIL lvl1_lives: got %0d expected 2", livesLeft); end
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL lvl1_count: got %0d expected 0", userCount); end
    checks++; if (difference !== 4'd0) begin errors++; $display("FAIL lvl1_diff: got %0d expected 0", difference); end
    checks++; if (levelPass !== 1'b0) begin errors++; $display("FAIL lvl1_pass: got %0d expected 0", levelPass); end
    checks++; if (secsLeft !== 8'd2) begin errors++; $display("FAIL lvl1_secs: got %0d expected 2", secsLeft); end
    doTicks(2);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL lvl1_game_phase: got %0d expected 2", phase); end
    checks++; if (secsLeft !== 8'd3) begin errors++; $display("FAIL lvl1_game_secs: got %0d expected 3", secsLeft); end
    $display("test_pass_level0 done: level=%0d secs=%0d", curLevel, secsLeft);
  endtask

  task automatic test_fail_and_lose();
    doUps(2);
    doTicks(3);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL fail_answer: got %0d expected 3", phase); end
    doTicks(2);
    checks++; if (difference !== 4'd3) begin errors++; $display("FAIL fail_diff: got %0d expected 3", difference); end
    checks++; if (levelPass !== 1'b0) begin errors++; $display("FAIL fail_verdict: got %0d expected 0", levelPass); end
    doTick();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL retry_phase: got %0d expected 1", phase); end
    checks++; if (livesLeft !== 4'd1) begin errors++; $display("FAIL retry_lives: got %0d expected 1", livesLeft); end
    checks++; if (curLevel !== 4'd1) begin errors++; $display("FAIL retry_level: got %0d expected 1", curLevel); end
    doTicks(2);
    doUps(2);
    doTicks(3);
    doTicks(2);
    checks++; if (levelPass !== 1'b0) begin errors++; $display("FAIL fail2_verdict: got %0d expected 0", levelPass); end
    doTick();
    checks++; if (phase !== 3'd6) begin errors++; $display("FAIL lose_phase: got %0d expected 6", phase); end
    checks++; if (livesLeft !== 4'd0) begin errors++; $display("FAIL lose_lives: got %0d expected 0", livesLeft); end
    checks++; if (secsLeft !== 8'd0) begin errors++; $display("FAIL lose_secs: got %0d expected 0", secsLeft); end
    checks++; if (curLevel !== 4'd1) begin errors++; $display("FAIL lose_level: got %0d expected 1", curLevel); end
    doTick();
    checks++; if (phase !== 3'd6) begin errors++; $display("FAIL lose_hold: got %0d expected 6", phase); end
    $display("test_fail_and_lose done: phase=%0d lives=%0d", phase, livesLeft);
  endtask

  task automatic test_win_restart();
    doStart();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL lose_restart_phase: got %0d expected 1", phase); end
    checks++; if (curLevel !== 4'd0) begin errors++; $display("FAIL lose_restart_level: got %0d expected 0", curLevel); end
    checks++; if (livesLeft !== 4'd2) begin errors++; $display("FAIL lose_restart_lives: got %0d expected 2", livesLeft); end
    // Level 0 with no presses: |0-5| = 5, fail.
    doTicks(2); doTicks(4); doTicks(2);
    checks++; if (difference !== 4'd5) begin errors++; $display("FAIL zero_diff: got %0d expected 5", difference); end
    doTick();
    checks++; if (livesLeft !== 4'd1) begin errors++; $display("FAIL zero_lives: got %0d expected 1", livesLeft); end
    // Level 0 with 4 presses: |4-5| = 1, within tolerance.
    doTicks(2); doUps(4); doTicks(4); doTicks(2);
    checks++; if (levelPass !== 1'b1) begin errors++; $display("FAIL low_side_pass: got %0d expected 1", levelPass); end
    doTick();
    checks++; if (curLevel !== 4'd1) begin errors++; $display("FAIL low_side_level: got %0d expected 1", curLevel); end
    // Level 1 exact answer.
    doTicks(2); doUps(5); doTicks(3); doTicks(2);
    checks++; if (difference !== 4'd0) begin errors++; $display("FAIL exact_diff: got %0d expected 0", difference); end
    doTick();
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL win_phase: got %0d expected 5", phase); end
    checks++; if (secsLeft !== 8'd0) begin errors++; $display("FAIL win_secs: got %0d expected 0", secsLeft); end
    checks++; if (curLevel !== 4'd1) begin errors++; $display("FAIL win_level: got %0d expected 1", curLevel); end
    doTick();
    checks++; if (phase !== 3'd5) begin errors++; $display("FAIL win_hold: got %0d expected 5", phase); end
    doStart();
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL win_restart_phase: got %0d expected 1", phase); end
    checks++; if (curLevel !== 4'd0) begin errors++; $display("FAIL win_restart_level: got %0d expected 0", curLevel); end
    checks++; if (livesLeft !== 4'd2) begin errors++; $display("FAIL win_restart_lives: got %0d expected 2", livesLeft); end
    checks++; if (secsLeft !== 8'd2) begin errors++; $display("FAIL win_restart_secs: got %0d expected 2", secsLeft); end
    $display("test_win_restart done: phase=%0d level=%0d", phase, curLevel);
  endtask

  task automatic test_saturation();
    doTicks(2);
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL sat_phase: got %0d expected 2", phase); end
    doUps(17);
    checks++; if (userCount !== 4'd15) begin errors++; $display("FAIL sat_top: got %0d expected 15", userCount); end
    doDowns(15);
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL sat_down: got %0d expected 0", userCount); end
    doDowns(1);
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL sat_bottom: got %0d expected 0", userCount); end
    doUps(1);
    userUp = 1'b1; userDown = 1'b1; step(); userUp = 1'b0; userDown = 1'b0;
    checks++; if (userCount !== 4'd1) begin errors++; $display("FAIL up_down_cancel: got %0d expected 1", userCount); end
    doUps(6);
    checks++; if (userCount !== 4'd7) begin errors++; $display("FAIL sat_seven: got %0d expected 7", userCount); end
    $display("test_saturation done: count=%0d", userCount);
  endtask

  task automatic test_reset_mid_game();
    reset = 1'b1; startBtn = 1'b1; step(); reset = 1'b0; startBtn = 1'b0;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_rst_phase: got %0d expected 0", phase); end
    checks++; if (userCount !== 4'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", userCount); end
    checks++; if (curLevel !== 4'd0) begin errors++; $display("FAIL mid_rst_level: got %0d expected 0", curLevel); end
    checks++; if (livesLeft !== 4'd2) begin errors++; $display("FAIL mid_rst_lives: got %0d expected 2", livesLeft); end
    checks++; if (secsLeft !== 8'd0) begin errors++; $display("FAIL mid_rst_secs: got %0d expected 0", secsLeft); end
    checks++; if (startGen !== 1'b0) begin errors++; $display("FAIL mid_rst_startGen: got %0d expected 0", startGen); end
    checks++; if (stopGen !== 1'b0) begin errors++; $display("FAIL mid_rst_stopGen: got %0d expected 0", stopGen); end
    step();
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_rst_hold: got %0d expected 0", phase); end
    $display("test_reset_mid_game done: phase=%0d", phase);
  endtask

  task automatic test_start_tick_idle();
    startBtn = 1'b1; tick = 1'b1; step(); startBtn = 1'b0; tick = 1'b0;
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL start_tick_phase: got %0d expected 1", phase); end
    checks++; if (secsLeft !== 8'd2) begin errors++; $display("FAIL start_tick_secs: got %0d expected 2", secsLeft); end
    doTick();
    checks++; if (secsLeft !== 8'd1) begin errors++; $display("FAIL start_tick_next: got %0d expected 1", secsLeft); end
    $display("test_start_tick_idle done: phase=%0d secs=%0d", phase, secsLeft);
  endtask

  initial begin
    test_reset();
    test_phase_timing();
    test_pass_level0();
    test_fail_and_lose();
    test_win_restart();
    test_saturation();
    test_reset_mid_game();
    test_start_tick_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
